bullet_flight_controller: RTL and testbench
===========================================

Name: bullet_flight_controller

Overview:
- Sequences the single on-screen bullet: accepts a fire request, spawns the bullet at the gun column, and advances it upward once per frame.
- Retires the bullet on a hit or when it leaves the top of the screen, and tracks remaining ammo per round.
- Drives the pos_x / signed pos_y inputs of the bullet drawer; sits between the trigger/gun logic, the collision logic and the VGA drawing path.

Parameters:
- SPEED, 4: pixels the bullet rises per frame_tick.
- START_Y, 440: spawn row (signed 10-bit).
- BULLET_H, 10: bullet height used for the off-screen test; must be < 22.
- MAX_X, 632: largest legal spawn column (screen width minus bullet width 8).
- AMMO, 3: shots per round.
- COOLDOWN_FRAMES, 15: frame_ticks of dead time after a shot ends (only with the optional feature).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- frame_tick  in  1  one-cycle pulse, once per frame (end of visible area).
- fire  in  1  trigger request, level or pulse; sampled each cycle.
- gun_x  in  10  current gun column, unsigned.
- hit  in  1  one-cycle pulse from collision logic: bullet struck a duck.
- reload  in  1  one-cycle pulse: new round, restore ammo.
- pos_x  out  10  bullet column to the drawer.
- pos_y  out  10 signed  bullet top row to the drawer.
- active  out  1  bullet in flight.
- ready  out  1  a fire request would be accepted this cycle.
- hit_pulse  out  1  one-cycle pulse: shot ended by hit.
- miss_pulse  out  1  one-cycle pulse: shot left the screen.
- ammo  out  2  shots remaining.

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high. All outputs are registered.
- Reset values:
  - state IDLE, pos_x=0, pos_y=PARK_Y.
  - active=0, hit_pulse=0, miss_pulse=0, ammo=AMMO.
  - ready=1 on the cycle after reset deasserts.
- PARK_Y = -32 (10'sh3E0). While the bullet is not in flight, pos_y holds PARK_Y so the drawer's row window never matches any vcount.
- States:
  - IDLE: ready = (ammo != 0).
    - fire && ready -> FLYING.
    - Next edge: pos_x = min(gun_x, MAX_X), pos_y = START_Y, active=1, ammo decremented.
    - Latency: fire to active is 1 clock.
  - FLYING:
    - On frame_tick: next_y = pos_y - SPEED, computed in 11-bit signed arithmetic.
    - If next_y < -BULLET_H: miss. pos_y=PARK_Y, active=0, miss_pulse=1 for one cycle, go to END. Otherwise pos_y = next_y.
    - hit in any FLYING cycle: pos_y=PARK_Y, active=0, hit_pulse=1 for one cycle, go to END.
    - hit and frame_tick in the same cycle: hit wins, no miss_pulse.
    - fire while FLYING is ignored, not queued. pos_x is frozen during flight.
  - END: transient, one cycle. Goes to COOLDOWN if the feature is compiled in, else IDLE.
- hit while IDLE or END is ignored.
- reload: ammo=AMMO next edge, in any state. It does not cancel a bullet in flight.
  - reload and an accepted fire in the same cycle: ammo = AMMO-1.
- ammo saturates at 0. With ammo=0, ready=0 and fire has no effect.
- reset mid-flight: next edge returns to the reset values. No hit_pulse or miss_pulse is emitted.

Optional Feature:
- Macro: BULLET_COOLDOWN_EN.
- Defined:
  - END -> COOLDOWN.
  - A frame counter loads COOLDOWN_FRAMES and decrements on each frame_tick.
  - Returns to IDLE on the tick that reaches 0.
  - ready=0 throughout COOLDOWN; fire is ignored; reload still applies.
- Undefined: the COOLDOWN state and its counter do not exist. END -> IDLE, so ready returns 2 cycles after the hit/miss pulse.

Test Plan:
- Reset, then fire=1 with gun_x=100 -> next cycle active=1, pos_x=100, pos_y=440, ammo=2. After 10 frame_ticks -> pos_y=400.
- Fire with gun_x=700 -> pos_x=632. No hit: after tick 112 pos_y=-8. Tick 113 -> miss_pulse=1 for 1 cycle, active=0, pos_y=-32.
- In flight, assert hit and frame_tick in the same cycle -> hit_pulse=1, miss_pulse=0, pos_y=-32. Holding fire during flight -> no respawn until back in IDLE.
- Fire 3 shots to completion -> ammo=0, ready=0; a 4th fire is ignored. Pulse reload -> ammo=3, ready=1.
- Reset asserted at pos_y=200 mid-flight -> next edge active=0, pos_y=-32, ammo=3, no pulses.
- With BULLET_COOLDOWN_EN: after a hit, ready stays 0 for 15 frame_ticks, then 1; a fire during cooldown is ignored. Without the macro: ready=1 two cycles after hit_pulse.

Source files
------------

// File: rtl/bullet_flight_controller.sv
// -----------------------------------------------------------------------------
// bullet_flight_controller
//
// Sequences the single on-screen bullet. A fire request spawns the bullet at
// the gun column (clamped to MAX_X) on row START_Y; each frame_tick moves it up
// by SPEED pixels. The shot ends on a hit pulse or when the bullet's top row
// drops below -BULLET_H. Ammo is counted per round and restored by reload.
//
// Optional feature macro: BULLET_COOLDOWN_EN
//   When defined, a COOLDOWN state follows every shot and blocks firing for
//   COOLDOWN_FRAMES frame_ticks. When undefined, that state and its counter
//   are not built.
//
// Ports:
//   clk        in   system clock
//   reset      in   synchronous, active-high reset
//   frame_tick in   one-cycle pulse per frame
//   fire       in   trigger request (level or pulse)
//   gun_x      in   [9:0] gun column, unsigned
//   hit        in   one-cycle pulse from collision logic
//   reload     in   one-cycle pulse, restores ammo
//   pos_x      out  [9:0] bullet column
//   pos_y      out  [9:0] signed bullet top row (PARK_Y when not in flight)
//   active     out  bullet in flight
//   ready      out  a fire request would be accepted this cycle
//   hit_pulse  out  one-cycle pulse: shot ended by hit
//   miss_pulse out  one-cycle pulse: shot left the screen
//   ammo       out  [1:0] shots remaining
// -----------------------------------------------------------------------------
module bullet_flight_controller #(
  parameter int SPEED           = 4,
  parameter int START_Y         = 440,
  parameter int BULLET_H        = 10,
  parameter int MAX_X           = 632,
  parameter int AMMO            = 3,
  parameter int COOLDOWN_FRAMES = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_tick,
  input  logic              fire,
  input  logic [9:0]        gun_x,
  input  logic              hit,
  input  logic              reload,
  output logic [9:0]        pos_x,
  output logic signed [9:0] pos_y,
  output logic              active,
  output logic              ready,
  output logic              hit_pulse,
  output logic              miss_pulse,
  output logic [1:0]        ammo
);

  // Parked row keeps the drawer's row window away from every vcount.
  localparam logic signed [9:0]  PARK_Y   = -10'sd32;
  localparam logic signed [9:0]  START_YC = 10'(START_Y);
  localparam logic [9:0]         MAX_XC   = 10'(MAX_X);
  localparam logic [1:0]         AMMO_C   = 2'(AMMO);
  localparam logic signed [10:0] SPEED_C  = 11'(SPEED);
  localparam logic signed [10:0] MISS_LIM = 11'(-BULLET_H);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FLY  = 2'd1,
    S_END  = 2'd2
`ifdef BULLET_COOLDOWN_EN
    ,S_COOL = 2'd3
`endif
  } state_t;

  state_t              state_q, state_d;
  logic [9:0]          pos_x_q, pos_x_d;
  logic signed [9:0]   pos_y_q, pos_y_d;
  logic                active_q, active_d;
  logic                ready_q, ready_d;
  logic                hit_pulse_q, hit_pulse_d;
  logic                miss_pulse_q, miss_pulse_d;
  logic [1:0]          ammo_q, ammo_d;
  logic signed [10:0]  next_y;
  logic                fire_ok;

`ifdef BULLET_COOLDOWN_EN
  localparam int CNT_W = $clog2(COOLDOWN_FRAMES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  // Next-state, datapath and output computation.
  always_comb begin
    state_d      = state_q;
    pos_x_d      = pos_x_q;
    pos_y_d      = pos_y_q;
    active_d     = active_q;
    hit_pulse_d  = 1'b0;
    miss_pulse_d = 1'b0;
    ammo_d       = reload ? AMMO_C : ammo_q;
    // ready_q is only ever set while IDLE with ammo left.
    fire_ok      = fire & ready_q;
    // Sign-extend so the step below row 0 cannot wrap.
    next_y       = {pos_y_q[9], pos_y_q} - SPEED_C;
`ifdef BULLET_COOLDOWN_EN
    cnt_d        = cnt_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (fire_ok) begin
          state_d  = S_FLY;
          pos_x_d  = (gun_x > MAX_XC) ? MAX_XC : gun_x;
          pos_y_d  = START_YC;
          active_d = 1'b1;
          // Reload in the same cycle yields AMMO-1.
          ammo_d   = ammo_d - 2'd1;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_FLY: begin
        // A hit outranks a simultaneous frame_tick.
        if (hit) begin
          state_d     = S_END;
          pos_y_d     = PARK_Y;
          active_d    = 1'b0;
          hit_pulse_d = 1'b1;
        end else if (frame_tick) begin
          if (next_y < MISS_LIM) begin
            state_d      = S_END;
            pos_y_d      = PARK_Y;
            active_d     = 1'b0;
            miss_pulse_d = 1'b1;
          end else begin
            pos_y_d = next_y[9:0];
          end
        end else begin
          state_d = S_FLY;
        end
      end
      S_END: begin
`ifdef BULLET_COOLDOWN_EN
        state_d = S_COOL;
        cnt_d   = CNT_W'(COOLDOWN_FRAMES);
`else
        state_d = S_IDLE;
`endif
      end
`ifdef BULLET_COOLDOWN_EN
      S_COOL: begin
        if (frame_tick) begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q <= CNT_W'(1)) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_COOL;
          end
        end else begin
          state_d = S_COOL;
        end
      end
`endif
      default: begin
        state_d  = S_IDLE;
        pos_y_d  = PARK_Y;
        active_d = 1'b0;
      end
    endcase

    // Requiring IDLE on both sides of the edge delays ready one cycle after
    // leaving END, and drops it on the very edge that accepts a shot.
    ready_d = (state_q == S_IDLE) && (state_d == S_IDLE) && (ammo_d != 2'd0);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      pos_x_q      <= 10'd0;
      pos_y_q      <= PARK_Y;
      active_q     <= 1'b0;
      ready_q      <= 1'b1;
      hit_pulse_q  <= 1'b0;
      miss_pulse_q <= 1'b0;
      ammo_q       <= AMMO_C;
`ifdef BULLET_COOLDOWN_EN
      cnt_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      pos_x_q      <= pos_x_d;
      pos_y_q      <= pos_y_d;
      active_q     <= active_d;
      ready_q      <= ready_d;
      hit_pulse_q  <= hit_pulse_d;
      miss_pulse_q <= miss_pulse_d;
      ammo_q       <= ammo_d;
`ifdef BULLET_COOLDOWN_EN
      cnt_q        <= cnt_d;
`endif
    end
  end

  assign pos_x      = pos_x_q;
  assign pos_y      = pos_y_q;
  assign active     = active_q;
  assign ready      = ready_q;
  assign hit_pulse  = hit_pulse_q;
  assign miss_pulse = miss_pulse_q;
  assign ammo       = ammo_q;

endmodule

// File: tb/tb_bullet_flight_controller.sv
module tb_bullet_flight_controller;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              frame_tick = 1'b0;
  logic              fire = 1'b0;
  logic [9:0]        gun_x = 10'd0;
  logic              hit = 1'b0;
  logic              reload = 1'b0;
  logic [9:0]        pos_x;
  logic signed [9:0] pos_y;
  logic              active;
  logic              ready;
  logic              hit_pulse;
  logic              miss_pulse;
  logic [1:0]        ammo;

  int    errors = 0;
  int    checks = 0;
  int    exp_q[$];
  string tag_q[$];

  bullet_flight_controller dut (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .fire       (fire),
    .gun_x      (gun_x),
    .hit        (hit),
    .reload     (reload),
    .pos_x      (pos_x),
    .pos_y      (pos_y),
    .active     (active),
    .ready      (ready),
    .hit_pulse  (hit_pulse),
    .miss_pulse (miss_pulse),
    .ammo       (ammo)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string tag, input int val);
    tag_q.push_back(tag);
    exp_q.push_back(val);
  endtask

  task automatic chk(input int obs);
    int    e;
    string t;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: got %0d expected queued value", obs);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s: got %0d expected %0d", t, obs, e);
      end
    end
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      step();
    end
  endtask

  initial begin
    // Reset state
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    push("rst_active", 0); push("rst_pos_y", -32); push("rst_pos_x", 0);
    push("rst_ammo", 3); push("rst_ready", 1); push("rst_hit", 0); push("rst_miss", 0);
    step();
    chk(active); chk(int'(pos_y)); chk(pos_x); chk(ammo); chk(ready);
    chk(hit_pulse); chk(miss_pulse);

    // Hit while idle is ignored
    hit = 1'b1;
    push("idle_hit", 0);
    step();
    hit = 1'b0;
    chk(hit_pulse);

    // First shot at column 100
    gun_x = 10'd100; fire = 1'b1;
    push("s1_active", 1); push("s1_pos_x", 100); push("s1_pos_y", 440);
    push("s1_ammo", 2); push("s1_ready", 0);
    step();
    fire = 1'b0;
    chk(active); chk(pos_x); chk(int'(pos_y)); chk(ammo); chk(ready);
    push("s1_y10", 400);
    frames(10);
    chk(int'(pos_y));

    // Hit and frame_tick together, fire held: hit wins
    hit = 1'b1; frame_tick = 1'b1; fire = 1'b1;
    push("hf_hit", 1); push("hf_miss", 0); push("hf_pos_y", -32); push("hf_active", 0);
    step();
    hit = 1'b0; frame_tick = 1'b0;
    chk(hit_pulse); chk(miss_pulse); chk(int'(pos_y)); chk(active);
    fire = 1'b0;
    push("hf_pulse_end", 0); push("hf_ready_1", 0);
    step();
    chk(hit_pulse); chk(ready);
    push("hf_ready_2", 1); push("hf_ammo", 2);
    step();
    chk(ready); chk(ammo);

    // Clamped spawn, fire held and gun moved during flight, fly to miss
    gun_x = 10'd700; fire = 1'b1;
    push("s2_pos_x", 632); push("s2_ammo", 1);
    step();
    chk(pos_x); chk(ammo);
    gun_x = 10'd50;
    push("s2_y112", -8); push("s2_active", 1); push("s2_frozen_x", 632);
    frames(112);
    chk(int'(pos_y)); chk(active); chk(pos_x);
    frame_tick = 1'b1;
    push("s2_miss", 1); push("s2_active_off", 0); push("s2_park", -32); push("s2_no_hit", 0);
    step();
    frame_tick = 1'b0; fire = 1'b0;
    chk(miss_pulse); chk(active); chk(int'(pos_y)); chk(hit_pulse);
    push("s2_miss_end", 0);
    step();
    chk(miss_pulse);
    push("s2_ready", 1);
    step();
    chk(ready);

    // Third shot ends by hit, ammo exhausted
    fire = 1'b1;
    push("s3_ammo", 0);
    step();
    fire = 1'b0;
    chk(ammo);
    hit = 1'b1;
    step();
    hit = 1'b0;
    step(); step();
    fire = 1'b1;
    step(); step();
    push("empty_ready", 0); push("empty_active", 0); push("empty_ammo", 0);
    step();
    chk(ready); chk(active); chk(ammo);
    fire = 1'b0;

    // Reload restores ammo and ready
    reload = 1'b1;
    push("rl_ammo", 3); push("rl_ready", 1);
    step();
    reload = 1'b0;
    chk(ammo); chk(ready);

    // Reload together with an accepted fire
    reload = 1'b1; fire = 1'b1; gun_x = 10'd300;
    push("rlf_ammo", 2); push("rlf_active", 1); push("rlf_pos_x", 300);
    step();
    reload = 1'b0; fire = 1'b0;
    chk(ammo); chk(active); chk(pos_x);

    // Reload mid-flight keeps the bullet
    push("fly_y200", 200);
    frames(60);
    chk(int'(pos_y));
    reload = 1'b1;
    push("flyrl_ammo", 3); push("flyrl_active", 1);
    step();
    reload = 1'b0;
    chk(ammo); chk(active);

    // Reset mid-flight
    reset = 1'b1;
    push("mr_active", 0); push("mr_pos_y", -32); push("mr_ammo", 3);
    push("mr_hit", 0); push("mr_miss", 0); push("mr_pos_x", 0);
    step();
    reset = 1'b0;
    chk(active); chk(int'(pos_y)); chk(ammo); chk(hit_pulse); chk(miss_pulse); chk(pos_x);
    push("mr_post_hit", 0); push("mr_post_miss", 0); push("mr_ready", 1);
    step();
    chk(hit_pulse); chk(miss_pulse); chk(ready);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
